// File: rtl/goertzel_pkg.sv
// Shared state encoding and default block constants for the Goertzel controller and datapath.
package goertzel_pkg;

  localparam int N_SAMPLES = 205;
  localparam int CNT_W     = 8;
  localparam int FIN_LAT   = 3;
  localparam int LAT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/goertzel_cnt.sv
// Up-counter with enable, synchronous clear (dominant over enable) and terminal-count flag.
module goertzel_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/goertzel_ctrl.sv
// Moore sequencer for a Goertzel block: clear delay regs, accumulate N_SAMPLES, run the
// final pipeline for FIN_LAT cycles, then hold the result until the consumer takes it.
module goertzel_ctrl #(
  parameter int N_SAMPLES = goertzel_pkg::N_SAMPLES,
  parameter int CNT_W     = goertzel_pkg::CNT_W,
  parameter int FIN_LAT   = goertzel_pkg::FIN_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             smp_valid,
  output logic             smp_ready,
  output logic             acc_en,
  output logic             acc_clr,
  output logic             fin_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] smp_cnt
);

  import goertzel_pkg::*;

  // Terminal compare on N-1 keeps the counter inside CNT_W even when N_SAMPLES == 2**CNT_W.
  localparam logic [CNT_W-1:0] SMP_TERM = CNT_W'(N_SAMPLES - 1);
  localparam logic [LAT_W-1:0] LAT_TERM = LAT_W'(FIN_LAT - 1);

  state_t state_q, state_d;

  logic             accept;
  logic             smp_tc;
  logic             lat_tc;
  logic             in_final;
  logic [LAT_W-1:0] lat_cnt;

  assign accept   = (state_q == S_ACCUM) && smp_valid;
  assign in_final = (state_q == S_FINAL);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_ACCUM;
      S_ACCUM: if (accept && smp_tc) state_d = S_FINAL;
      S_FINAL: if (lat_tc) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = start ? S_CLEAR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  goertzel_cnt #(.W(CNT_W)) u_smp_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (accept && !abort),
    .clr  (abort || (accept && smp_tc)),
    .term (SMP_TERM),
    .cnt  (smp_cnt),
    .tc   (smp_tc)
  );

  goertzel_cnt #(.W(LAT_W)) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (in_final && !abort),
    .clr  (abort || (in_final && lat_tc)),
    .term (LAT_TERM),
    .cnt  (lat_cnt),
    .tc   (lat_tc)
  );

  // acc_en is the only output that looks at an input: the sample handshake itself.
  assign smp_ready = (state_q == S_ACCUM);
  assign acc_clr   = (state_q == S_CLEAR);
  assign acc_en    = acc_clr || accept;
  assign fin_en    = in_final;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Directed bench for goertzel_ctrl (N_SAMPLES=4, FIN_LAT=3) plus an N_SAMPLES=1 instance.
module tb_goertzel_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int FL = 3;

  logic clk = 1'b0;
  logic rst, start, abort, smp_valid, res_ready;
  logic smp_ready, acc_en, acc_clr, fin_en, res_valid, busy;
  logic [W-1:0] smp_cnt;
  logic n1_smp_ready, n1_acc_en, n1_acc_clr, n1_fin_en, n1_res_valid, n1_busy;
  logic [W-1:0] n1_smp_cnt;
  logic [5:0] outs, n1_outs;

  int checks = 0;
  int errors = 0;

  // Output vector order: {smp_ready, acc_en, acc_clr, fin_en, res_valid, busy}
  assign outs    = {smp_ready, acc_en, acc_clr, fin_en, res_valid, busy};
  assign n1_outs = {n1_smp_ready, n1_acc_en, n1_acc_clr, n1_fin_en, n1_res_valid, n1_busy};

  always #5 clk = ~clk;

  goertzel_ctrl #(.N_SAMPLES(N), .CNT_W(W), .FIN_LAT(FL)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .acc_en(acc_en), .acc_clr(acc_clr), .fin_en(fin_en),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .smp_cnt(smp_cnt)
  );

  goertzel_ctrl #(.N_SAMPLES(1), .CNT_W(W), .FIN_LAT(FL)) u_n1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .smp_valid(smp_valid),
    .smp_ready(n1_smp_ready), .acc_en(n1_acc_en), .acc_clr(n1_acc_clr), .fin_en(n1_fin_en),
    .res_valid(n1_res_valid), .res_ready(res_ready), .busy(n1_busy), .smp_cnt(n1_smp_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; smp_valid = 1'b1; res_ready = 1'b1;
    #2;
    checks++;
    if (outs !== 6'b000000 || smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_async outs=%b cnt=%0d expected outs=000000 cnt=0", outs, smp_cnt);
    end
    tick;
    checks++;
    if (outs !== 6'b000000 || smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_held outs=%b cnt=%0d expected outs=000000 cnt=0", outs, smp_cnt);
    end
    rst = 1'b0; start = 1'b0; smp_valid = 1'b0; res_ready = 1'b0;
    tick;
  endtask

  task automatic test_nominal;
    logic [5:0] exp_o [10];
    logic [W-1:0] exp_c;
    exp_o = '{6'b000000, 6'b011001, 6'b110001, 6'b110001, 6'b110001, 6'b110001,
              6'b000101, 6'b000101, 6'b000101, 6'b000011};
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      smp_valid = 1'b1;
      #1;
      exp_c = (c >= 2 && c <= 5) ? W'(c - 2) : '0;
      checks++;
      if (outs !== exp_o[c] || smp_cnt !== exp_c) begin
        errors++;
        $display("FAIL nominal_cycle%0d outs=%b cnt=%0d expected outs=%b cnt=%0d",
                 c, outs, smp_cnt, exp_o[c], exp_c);
      end
      tick;
    end
    start = 1'b0; smp_valid = 1'b0; res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b000000) begin
      errors++;
      $display("FAIL nominal_release outs=%b expected 000000", outs);
    end
  endtask

  task automatic test_toggle;
    int pulses;
    logic [W-1:0] exp_c;
    pulses = 0;
    start = 1'b1; #1; tick; start = 1'b0;
    tick;
    for (int i = 0; i < 7; i++) begin
      smp_valid = (i % 2 == 0);
      #1;
      if (acc_en === 1'b1) pulses++;
      exp_c = W'((i + 1) / 2);
      checks++;
      if (smp_cnt !== exp_c || smp_ready !== 1'b1) begin
        errors++;
        $display("FAIL toggle_step%0d cnt=%0d rdy=%b expected cnt=%0d rdy=1", i, smp_cnt, smp_ready, exp_c);
      end
      tick;
    end
    smp_valid = 1'b0;
    #1;
    checks++;
    if (pulses != 4 || outs !== 6'b000101 || smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL toggle_final pulses=%0d outs=%b cnt=%0d expected pulses=4 outs=000101 cnt=0",
               pulses, outs, smp_cnt);
    end
  endtask

  task automatic test_done_hold;
    tick; tick; tick;
    for (int i = 0; i < 10; i++) begin
      res_ready = 1'b0;
      #1;
      checks++;
      if (outs !== 6'b000011) begin
        errors++;
        $display("FAIL done_hold%0d outs=%b expected 000011", i, outs);
      end
      tick;
    end
    res_ready = 1'b1; start = 1'b1;
    #1;
    tick;
    res_ready = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b011001) begin
      errors++;
      $display("FAIL done_to_clear outs=%b expected 011001", outs);
    end
  endtask

  task automatic test_abort;
    tick;
    smp_valid = 1'b1;
    tick; tick;
    smp_valid = 1'b0;
    #1;
    checks++;
    if (smp_cnt !== 8'd2 || smp_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre cnt=%0d rdy=%b expected cnt=2 rdy=1", smp_cnt, smp_ready);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b000000 || smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_idle outs=%b cnt=%0d expected outs=000000 cnt=0", outs, smp_cnt);
    end
    start = 1'b1; #1; tick; start = 1'b0;
    tick;
    smp_valid = 1'b1;
    tick; tick; tick;
    #1;
    checks++;
    if (outs !== 6'b110001 || smp_cnt !== 8'd3) begin
      errors++;
      $display("FAIL abort_fresh3 outs=%b cnt=%0d expected outs=110001 cnt=3", outs, smp_cnt);
    end
    tick;
    smp_valid = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b000101) begin
      errors++;
      $display("FAIL abort_fresh4 outs=%b expected 000101", outs);
    end
    tick; tick; tick;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  task automatic test_rst_final;
    int seen;
    seen = 0;
    start = 1'b1; #1; tick; start = 1'b0;
    tick;
    smp_valid = 1'b1;
    tick; tick; tick; tick;
    smp_valid = 1'b0;
    tick;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 6'b000000 || smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_final_async outs=%b cnt=%0d expected outs=000000 cnt=0", outs, smp_cnt);
    end
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp_valid = 1'b1;
      #1;
      if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
      tick;
    end
    smp_valid = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_final_quiet bad_cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_ignore;
    for (int i = 0; i < 3; i++) begin
      smp_valid = 1'b1;
      #1;
      checks++;
      if (outs !== 6'b000000 || smp_cnt !== 8'd0) begin
        errors++;
        $display("FAIL idle_valid%0d outs=%b cnt=%0d expected outs=000000 cnt=0", i, outs, smp_cnt);
      end
      tick;
    end
    smp_valid = 1'b0;
    start = 1'b1; #1; tick; start = 1'b0;
    tick;
    smp_valid = 1'b1;
    tick;
    smp_valid = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs !== 6'b100001 || smp_cnt !== 8'd1) begin
        errors++;
        $display("FAIL busy_start%0d outs=%b cnt=%0d expected outs=100001 cnt=1", i, outs, smp_cnt);
      end
      tick;
    end
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_n1;
    start = 1'b1; #1; tick; start = 1'b0;
    #1;
    checks++;
    if (n1_outs !== 6'b011001) begin
      errors++;
      $display("FAIL n1_clear outs=%b expected 011001", n1_outs);
    end
    tick;
    smp_valid = 1'b1;
    #1;
    checks++;
    if (n1_outs !== 6'b110001 || n1_smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL n1_accum outs=%b cnt=%0d expected outs=110001 cnt=0", n1_outs, n1_smp_cnt);
    end
    tick;
    smp_valid = 1'b0;
    #1;
    checks++;
    if (n1_outs !== 6'b000101 || n1_smp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL n1_final outs=%b cnt=%0d expected outs=000101 cnt=0", n1_outs, n1_smp_cnt);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_toggle;
    test_done_hold;
    test_abort;
    test_rst_final;
    test_ignore;
    test_n1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/goertzel_ctrl.md
GOERTZEL_CTRL -- requirements
Module: goertzel_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 205: samples per Goertzel block, legal range 1..2**CNT_W.
REQ-002 SHALL have parameter CNT_W, default 8: sample-counter width.
REQ-003 SHALL have parameter FIN_LAT, default 3: final-stage pipeline depth in cycles, legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a new block; ignored unless busy=0.
REQ-007 SHALL have port abort, input, 1 bit: cancel the current block.
REQ-008 SHALL have port smp_valid, input, 1 bit: the source presents a sample.
REQ-009 SHALL have port smp_ready, output, 1 bit: the controller accepts a sample.
REQ-010 SHALL have port acc_en, output, 1 bit: enable for the delay registers s1/s2.
REQ-011 SHALL have port acc_clr, output, 1 bit: datapath selects zero as the delay-register input.
REQ-012 SHALL have port fin_en, output, 1 bit: enable for the final power/magnitude pipeline.
REQ-013 SHALL have port res_valid, output, 1 bit: the result is held stable in the datapath.
REQ-014 SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port smp_cnt, output, CNT_W bits: number of samples accepted in the current block.

Function
REQ-017 SHALL be a Moore FSM with states IDLE, CLEAR, ACCUM, FINAL and DONE; all outputs SHALL be decoded from registered state, except acc_en.
REQ-018 IDLE: smp_ready=0 and all enables low; start=1 SHALL move to CLEAR.
REQ-019 CLEAR: SHALL last exactly one cycle with acc_clr=1 and acc_en=1, zeroing s1/s2, then move to ACCUM.
REQ-020 ACCUM: smp_ready=1; acc_en SHALL equal smp_valid AND smp_ready (combinational).
REQ-021 Each accepted sample SHALL increment smp_cnt by 1.
REQ-022 ACCUM SHALL move to FINAL on the cycle the N_SAMPLES-th sample is accepted, and smp_cnt SHALL clear to 0 on that move.
REQ-023 ACCUM SHALL wait indefinitely while smp_valid=0, with no timeout.
REQ-024 FINAL: fin_en=1 for exactly FIN_LAT consecutive cycles, counted by a latency counter, then move to DONE.
REQ-025 DONE: res_valid=1 and all enables low; the state SHALL hold until res_ready=1.
REQ-026 In DONE, res_ready=1 SHALL move to IDLE; res_ready=1 and start=1 in the same cycle SHALL move directly to CLEAR.
REQ-027 abort=1 in any state SHALL move to IDLE on the next edge, clearing smp_cnt and the latency counter; abort SHALL take priority over start, res_ready and sample acceptance in the same cycle.
REQ-028 Boundary N_SAMPLES=1: ACCUM SHALL leave after a single accepted sample.
REQ-029 Boundary N_SAMPLES=2**CNT_W: the terminal compare SHALL use the value N_SAMPLES-1 on smp_cnt so the counter never wraps.
REQ-030 smp_valid outside ACCUM SHALL have no effect; smp_ready=0 guarantees no sample is consumed.
REQ-031 Latency: start sampled at edge k gives CLEAR in cycle k+1 and smp_ready from cycle k+2.
REQ-032 Latency: the last sample accepted at edge m gives fin_en in cycles m+1..m+FIN_LAT and res_valid from cycle m+FIN_LAT+1.

Reset
REQ-033 rst=1 SHALL asynchronously force state=IDLE, smp_cnt=0, latency counter=0, and smp_ready, acc_en, acc_clr, fin_en, res_valid and busy all to 0.
REQ-034 Assertion of rst in mid-block SHALL discard the block, and no res_valid SHALL follow.
REQ-035 After rst deasserts, the block SHALL take no action until a new start.

Structure
REQ-036 Package goertzel_pkg SHALL hold the state encoding typedef and the default constants N_SAMPLES, CNT_W and FIN_LAT, shared with the datapath.
REQ-037 Sub-module goertzel_cnt SHALL be a parameterised up-counter with enable, synchronous clear and terminal-count flag.
REQ-038 goertzel_cnt SHALL be instantiated twice: once as the sample counter and once as the latency counter.

Verification (N_SAMPLES=4, FIN_LAT=3)
REQ-039 Scenario: start at edge 0 with smp_valid held 1 -> acc_clr in cycle 1, acc_en in cycles 2-5, fin_en in cycles 6-8, res_valid from cycle 9.
REQ-040 Scenario: smp_valid toggled 1,0,1,0,... -> exactly 4 acc_en pulses, smp_cnt reading 0,1,1,2,2,3, then FINAL.
REQ-041 Scenario: res_ready held 0 for 10 cycles in DONE -> res_valid stays 1 with no enables; with res_ready=1 and start=1 together -> CLEAR on the next cycle.
REQ-042 Scenario: abort after 2 accepted samples -> IDLE next cycle with smp_cnt=0; a new start then requires 4 fresh samples.
REQ-043 Scenario: rst asserted during FINAL -> all outputs 0 immediately, with no res_valid afterwards.
REQ-044 Scenario: start while busy, and smp_valid while IDLE -> both ignored, with no change to state or smp_cnt.
